// File: rtl/input_capture.sv
// input_capture: free-running counter timestamping synchronized cap_in edges into a valid/ready slice; CAP_FILTER_EN adds a 3-cycle glitch filter
module input_capture #(
    parameter int N           = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         count_clr,
    input  logic [1:0]   edge_sel,
    input  logic         cap_in,
    input  logic         cap_ready,
    output logic [N-1:0] cap_val,
    output logic         cap_valid,
    input  logic         overrun_clr,
    output logic         overrun,
    output logic [N-1:0] count,
    output logic         ovf
);
    typedef enum logic {EMPTY, FULL} state_t;
`ifdef CAP_FILTER_EN
    localparam int ARM = SYNC_STAGES + 3;
`else
    localparam int ARM = SYNC_STAGES + 1;
`endif
    localparam int AW = $clog2(ARM + 1);
    logic [N-1:0]           count_q, count_d, cap_val_q, cap_val_d;
    logic                   ovf_q, ovf_d, overrun_q, overrun_d, p_q, p_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [AW-1:0]          arm_q, arm_d;
    state_t                 state_q, state_d;
    logic                   s, lvl, armed, rise, fall, ev, take;
    assign s = sync_q[SYNC_STAGES-1];
`ifdef CAP_FILTER_EN
    logic h1_q, h2_q;
    // p_q doubles as the held filtered level; it only follows s after three equal samples
    assign lvl = (s == h1_q && s == h2_q) ? s : p_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            h1_q <= 1'b0;
            h2_q <= 1'b0;
        end else begin
            h1_q <= s;
            h2_q <= h1_q;
        end
    end
`else
    assign lvl = s;
`endif
    assign armed = arm_q == AW'(ARM);
    assign rise  = lvl & ~p_q;
    assign fall  = ~lvl & p_q;
    assign ev    = armed & en & ((edge_sel[0] & rise) | (edge_sel[1] & fall));
    assign take  = ev & (state_q == EMPTY | cap_ready);
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], cap_in};
        p_d       = lvl;
        arm_d     = armed ? arm_q : arm_q + AW'(1);
        count_d   = count_clr ? '0 : en ? count_q + N'(1) : count_q;
        ovf_d     = ~count_clr & en & (count_q == '1);
        cap_val_d = take ? count_q : cap_val_q;
        state_d   = (ev | (state_q == FULL & ~cap_ready)) ? FULL : EMPTY;
        overrun_d = (ev & state_q == FULL & ~cap_ready) | (overrun_q & ~overrun_clr);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            p_q       <= 1'b0;
            arm_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cap_val_q <= '0;
            state_q   <= EMPTY;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            p_q       <= p_d;
            arm_q     <= arm_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            cap_val_q <= cap_val_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign cap_val   = cap_val_q;
    assign cap_valid = state_q == FULL;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_input_capture.sv
// tb_input_capture: scoreboard bench with a delayed-level reference model plus directed scenarios
module tb_input_capture;
    localparam int N = 16;
    localparam int S = 2;
    logic         clk = 1'b0, rst = 1'b1, en = 1'b1, count_clr = 1'b0, cap_in = 1'b0;
    logic         cap_ready = 1'b1, overrun_clr = 1'b0;
    logic [1:0]   edge_sel = 2'b01;
    logic [N-1:0] cap_val, count;
    logic         cap_valid, overrun, ovf;
    int           vecs = 0, errs = 0, npop = 0, novf = 0;
    logic [N-1:0] last_val = '0, c0, c0e, c1;
    logic [N-1:0] sb[$];
    logic [N-1:0] m_cnt = '0;
    bit           m_ovf, m_full, m_ovr;
    bit           hist[$];
    int           since = 0;

    always #5 clk = ~clk;

    input_capture #(.N(N), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .en(en), .count_clr(count_clr), .edge_sel(edge_sel),
        .cap_in(cap_in), .cap_ready(cap_ready), .cap_val(cap_val), .cap_valid(cap_valid),
        .overrun_clr(overrun_clr), .overrun(overrun), .count(count), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cnt(input logic [N-1:0] v);
        int n = 0;
        while (count !== v && n < 70000) begin
            tick();
            n++;
        end
        if (count !== v) begin
            vecs++;
            errs++;
            $display("FAIL wait_cnt: count %0d never reached %0d", count, v);
        end
    endtask

    // Reference: the detector sees cap_in exactly S samples late; a capture takes the count before the edge
    always @(posedge clk) begin
        bit s, p, ev;
        if (rst) begin
            m_cnt = '0; m_ovf = 0; m_full = 0; m_ovr = 0; since = 0;
            sb.delete();
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back(1'b0);
        end else begin
            if (since < 1000) since++;
            s  = hist[S-1];
            p  = hist[S];
            ev = since >= S + 2 && en && ((edge_sel[0] && s && !p) || (edge_sel[1] && !s && p));
            if (ev && (!m_full || cap_ready)) sb.push_back(m_cnt);
            m_ovr  = (ev && m_full && !cap_ready) || (m_ovr && !overrun_clr);
            m_full = ev || (m_full && !cap_ready);
            m_ovf  = !count_clr && en && m_cnt == '1;
            m_cnt  = count_clr ? '0 : en ? m_cnt + N'(1) : m_cnt;
            hist.push_front(cap_in);
            void'(hist.pop_back());
        end
        #1;
        chk("count", 32'(count), 32'(m_cnt));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("cap_valid", 32'(cap_valid), 32'(m_full));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    end

    always @(negedge clk) begin
        if (ovf) novf++;
        if (!rst && cap_valid && cap_ready) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL cap_extra: got cap_val %0d, expected no capture", cap_val);
            end else begin
                chk("cap_val", 32'(cap_val), 32'(sb.pop_front()));
                last_val = cap_val;
                npop++;
            end
        end
    end

    initial begin
        tick(); tick();
        rst = 1'b0;
        wait_cnt(16'd100);
        cap_in = 1'b1;
        repeat (5) tick();
        chk("t1_val", 32'(last_val), 32'd102);
        chk("t1_npop", npop, 1);
        chk("t1_overrun", 32'(overrun), 32'd0);
        cap_in = 1'b0;
        repeat (4) tick();
        edge_sel = 2'b11;
        wait_cnt(16'd200);
        cap_in = 1'b1;
        wait_cnt(16'd250);
        cap_in = 1'b0;
        repeat (5) tick();
        chk("t2_npop", npop, 3);
        chk("t2_val", 32'(last_val), 32'd252);
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        edge_sel = 2'b10;
        wait_cnt(16'd200);
        cap_in = 1'b1;
        wait_cnt(16'd250);
        cap_in = 1'b0;
        repeat (5) tick();
        chk("t2f_npop", npop, 4);
        chk("t2f_val", 32'(last_val), 32'd252);
        edge_sel = 2'b01;
        cap_ready = 1'b0;
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        wait_cnt(16'd10);
        cap_in = 1'b1;
        wait_cnt(16'd25);
        cap_in = 1'b0;
        wait_cnt(16'd40);
        cap_in = 1'b1;
        wait_cnt(16'd50);
        chk("t3_held", 32'(cap_val), 32'd12);
        chk("t3_overrun", 32'(overrun), 32'd1);
        cap_ready = 1'b1;
        tick(); tick();
        chk("t3_pop", 32'(last_val), 32'd12);
        chk("t3_npop", npop, 5);
        chk("t3_drop", 32'(cap_valid), 32'd0);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        chk("t3_ovclr", 32'(overrun), 32'd0);
        cap_in = 1'b0;
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        wait_cnt(16'd65535);
        cap_in = 1'b1;
        repeat (5) tick();
        chk("t4_wrap_val", 32'(last_val), 32'd1);
        chk("t4_npop", npop, 6);
        chk("t4_novf", novf, 1);
        cap_in = 1'b0;
        repeat (4) tick();
        c0 = m_cnt;
        c0e = c0 + 16'd2;
        cap_in = 1'b1;
        tick(); tick();
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        chk("t4_clr_count", 32'(count), 32'd0);
        tick();
        chk("t4_clr_val", 32'(last_val), 32'(c0e));
        chk("t4_clr_npop", npop, 7);
        edge_sel = 2'b11;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        repeat (10) tick();
        chk("t5_rst_high", npop, 7);
        chk("t5_valid", 32'(cap_valid), 32'd0);
        c1 = m_cnt;
        en = 1'b0;
        cap_in = 1'b0; repeat (3) tick();
        cap_in = 1'b1; repeat (3) tick();
        cap_in = 1'b0; repeat (4) tick();
        chk("t5_frozen", 32'(count), 32'(c1));
        en = 1'b1;
        repeat (6) tick();
        chk("t5_en_npop", npop, 7);
        repeat (4000) begin
            rst         = $urandom_range(0, 999) < 3;
            en          = $urandom_range(0, 9) != 0;
            count_clr   = $urandom_range(0, 49) == 0;
            overrun_clr = $urandom_range(0, 19) == 0;
            cap_ready   = $urandom_range(0, 9) < 7;
            if ($urandom_range(0, 3) == 0) cap_in = ~cap_in;
            if ($urandom_range(0, 31) == 0) edge_sel = 2'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b0; en = 1'b1; count_clr = 1'b0; overrun_clr = 1'b0; cap_ready = 1'b1;
        repeat (10) tick();
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
